// File: rtl/xor_cipher_pkg.sv
// Shared constants and types for the xor_cipher configuration chain and its load sequencer.
package xor_cipher_pkg;

    localparam int CFG_W     = 64;
    localparam int TAPS_W    = 32;
    localparam int STATE_W   = 32;
    localparam int BIT_CNT_W = $clog2(CFG_W);

    localparam logic [TAPS_W-1:0]  TAPS_DEFAULT  = 32'h0000_0060;
    localparam logic [STATE_W-1:0] STATE_DEFAULT = 32'h0000_0055;

    typedef enum logic {
        RUN   = 1'b0,
        SHIFT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/xor_cipher_cfg_ctrl_if.sv
// Load-request and readback handshakes between a configuration requester and the sequencer.
interface xor_cipher_cfg_ctrl_if;
    import xor_cipher_pkg::*;

    logic                 load_valid;
    logic                 load_ready;
    logic [TAPS_W-1:0]    load_taps;
    logic [STATE_W-1:0]   load_state;
    logic                 rb_valid;
    logic                 rb_ready;
    logic [CFG_W-1:0]     rb_data;

    modport master (
        output load_valid, load_taps, load_state, rb_ready,
        input  load_ready, rb_valid, rb_data
    );

    modport slave (
        input  load_valid, load_taps, load_state, rb_ready,
        output load_ready, rb_valid, rb_data
    );

endinterface

// File: rtl/xor_cipher_cfg_ctrl_cfg_serdes.sv
// Serialiser for the outgoing config word, deserialiser for the returning one, and the bit counter.
module xor_cipher_cfg_ctrl_cfg_serdes
    import xor_cipher_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [CFG_W-1:1] load_word,
    input  logic             ser_in,
    output logic             next_bit,
    output logic [CFG_W-1:0] capture_next,
    output logic             last_bit
);

    // Bit 0 of each word is never stored here: the outgoing one goes straight to the
    // cfg_i register, the incoming one arrives on the final edge via capture_next.
    logic [CFG_W-1:1]     shift_reg;
    logic [CFG_W-1:1]     capture;
    logic [BIT_CNT_W-1:0] bit_cnt;

    assign next_bit     = shift_reg[1];
    assign capture_next = {ser_in, capture};
    assign last_bit     = (bit_cnt == BIT_CNT_W'(CFG_W - 1));

    always_ff @(posedge clk) begin
        if (load) begin
            shift_reg <= load_word;
        end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
            capture   <= capture_next[CFG_W-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xor_cipher_cfg_ctrl.sv
// Loads a {taps, seed} word into xor_cipher over its serial chain, returns the old word,
// and counts free-running keystream cycles between loads.
module xor_cipher_cfg_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int KS_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xor_cipher_cfg_ctrl_if.slave  bus,
    output logic                  cfg_en,
    output logic                  cfg_i,
    input  logic                  cfg_o,
    output logic                  shifting,
    output logic [KS_CNT_W-1:0]   ks_count
);

    ctrl_state_t      state;
    logic             rb_valid;
    logic [CFG_W-1:0] rb_data;
    logic             load_ready;
    logic             accept;
    logic [CFG_W-1:0] load_word;
    logic             next_bit;
    logic [CFG_W-1:0] capture_next;
    logic             last_bit;

    assign load_word  = {bus.load_taps, bus.load_state};
    assign load_ready = (state == RUN) && !rb_valid;
    assign accept     = load_ready && bus.load_valid;

    assign bus.load_ready = load_ready;
    assign bus.rb_valid   = rb_valid;
    assign bus.rb_data    = rb_data;
    assign shifting       = cfg_en;

    xor_cipher_cfg_ctrl_cfg_serdes u_cfg_serdes (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (accept),
        .shift_en     (state == SHIFT),
        .load_word    (load_word[CFG_W-1:1]),
        .ser_in       (cfg_o),
        .next_bit     (next_bit),
        .capture_next (capture_next),
        .last_bit     (last_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            cfg_en   <= 1'b0;
            cfg_i    <= 1'b0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
            ks_count <= '0;
        end else begin
            if (rb_valid && bus.rb_ready) begin
                rb_valid <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (ks_count != {KS_CNT_W{1'b1}}) begin
                        ks_count <= ks_count + 1'b1;
                    end
                    if (accept) begin
                        state  <= SHIFT;
                        cfg_en <= 1'b1;
                        cfg_i  <= load_word[0];
                    end
                end
                SHIFT: begin
                    // rb_valid is known low here: a load is only accepted with no readback pending.
                    if (last_bit) begin
                        state    <= RUN;
                        cfg_en   <= 1'b0;
                        cfg_i    <= 1'b0;
                        rb_data  <= capture_next;
                        rb_valid <= 1'b1;
                        ks_count <= '0;
                    end else begin
                        cfg_i <= next_bit;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_cipher_cfg_ctrl.sv
// Directed bench: sequencer wired to a behavioural xor_cipher configuration chain.
module tb_xor_cipher_cfg_ctrl;
    import xor_cipher_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic        cfg_i;
    logic        cfg_o;
    logic        shifting;
    logic [15:0] ks_count;

    int n_checks = 0;
    int n_errors = 0;

    xor_cipher_cfg_ctrl_if bus ();

    xor_cipher_cfg_ctrl #(.KS_CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .cfg_o    (cfg_o),
        .shifting (shifting),
        .ks_count (ks_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_n(logic [31:0] taps, logic [31:0] s, int n);
        for (int i = 0; i < n; i++) begin
            s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
        end
        return s;
    endfunction

    // Behavioural cipher: config chain shifts in from the top while cfg_en, else the LFSR state steps.
    logic [63:0] cipher_reg;
    int          run_edges;
    assign cfg_o = cipher_reg[0];

    always @(posedge clk) begin
        if (!rst_n) begin
            cipher_reg <= {TAPS_DEFAULT, STATE_DEFAULT};
        end else if (cfg_en) begin
            cipher_reg <= {cfg_i, cipher_reg[63:1]};
        end else begin
            cipher_reg[31:0] <= lfsr_n(cipher_reg[63:32], cipher_reg[31:0], 1);
        end
    end

    always @(posedge clk) begin
        if (!rst_n || cfg_en) run_edges <= 0;
        else                  run_edges <= run_edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int run_at_start;

    // Waits for cfg_en to rise; on return the bench sits in SHIFT cycle 0.
    task automatic wait_shift_start(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cfg_en) break;
        end
        check(tag, cfg_en, 1'b1);
        run_at_start = run_edges;
        bus.load_valid = 1'b0;
    endtask

    // Counts the SHIFT cycles from cycle 0; returns in the first RUN cycle after completion.
    task automatic finish_shift(input string tag, input logic [63:0] word, input logic [63:0] exp_rb);
        int cnt;
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!cfg_en) break;
            cnt++;
        end
        check({tag, "_len"}, 64'(cnt), 64'd64);
        check({tag, "_rbv"}, bus.rb_valid, 1'b1);
        check({tag, "_rb"}, bus.rb_data, exp_rb);
        check({tag, "_ks"}, ks_count, 16'd0);
        check({tag, "_cipher"}, cipher_reg, word);
    endtask

    task automatic request(input logic [31:0] taps, input logic [31:0] state);
        bus.load_taps  = taps;
        bus.load_state = state;
        bus.load_valid = 1'b1;
    endtask

    logic [63:0] rb_hold;
    int          gap;
    logic        seen_en;

    initial begin
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_taps  = '0;
        bus.load_state = '0;
        bus.rb_ready   = 1'b0;
        repeat (3) tick();
        check("rst_cfg_en", cfg_en, 1'b0);
        check("rst_rbv", bus.rb_valid, 1'b0);
        check("rst_rb", bus.rb_data, 64'd0);
        check("rst_ks", ks_count, 16'd0);
        check("rst_cfg_i", cfg_i, 1'b0);

        // Idle after reset
        rst_n   = 1'b1;
        seen_en = 1'b0;
        tick();
        check("idle_ready", bus.load_ready, 1'b1);
        for (int i = 1; i < 10; i++) begin
            seen_en |= cfg_en;
            tick();
        end
        seen_en |= cfg_en;
        check("idle_cfg_en", seen_en, 1'b0);
        check("idle_ks", ks_count, 16'd10);
        check("idle_rbv", bus.rb_valid, 1'b0);

        // First load: readback is the default taps and the LFSR state at shift start
        request(32'h8020_0003, 32'h0000_0001);
        wait_shift_start("l1_start");
        check("l1_shifting", shifting, 1'b1);
        bus.load_taps  = 32'hFFFF_FFFF;
        bus.load_state = 32'hFFFF_FFFF;
        finish_shift("l1", 64'h8020_0003_0000_0001,
                     {32'h0000_0060, lfsr_n(32'h60, 32'h55, run_at_start)});
        check("l1_rb_taps", bus.rb_data[63:32], 32'h0000_0060);

        // Second load blocked while readback is unread
        rb_hold = bus.rb_data;
        request(32'h0000_00C5, 32'h1234_5678);
        seen_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_en |= cfg_en;
        end
        check("blk_cfg_en", seen_en, 1'b0);
        check("blk_ready", bus.load_ready, 1'b0);
        check("blk_rb_hold", bus.rb_data, rb_hold);
        bus.rb_ready = 1'b1;
        tick();
        bus.rb_ready = 1'b0;
        check("pop_rbv", bus.rb_valid, 1'b0);
        check("pop_cfg_en", cfg_en, 1'b0);
        check("pop_ready", bus.load_ready, 1'b1);
        wait_shift_start("l2_start");
        finish_shift("l2", 64'h0000_00C5_1234_5678,
                     {32'h8020_0003, lfsr_n(32'h8020_0003, 32'h1, run_at_start)});
        check("l2_rb_taps", bus.rb_data[63:32], 32'h8020_0003);

        // Back-to-back loads with the readback consumer always ready
        bus.rb_ready = 1'b1;
        request(32'hA5A5_0001, 32'hCAFE_F00D);
        wait_shift_start("b1_start");
        finish_shift("b1", 64'hA5A5_0001_CAFE_F00D,
                     {32'h0000_00C5, lfsr_n(32'hC5, 32'h1234_5678, run_at_start)});
        request(32'h0F0F_1234, 32'h8000_0001);
        gap = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_en) break;
            gap++;
        end
        check("b2b_gap", 64'(gap), 64'd2);
        run_at_start   = run_edges;
        bus.load_valid = 1'b0;
        finish_shift("b2", 64'h0F0F_1234_8000_0001,
                     {32'hA5A5_0001, lfsr_n(32'hA5A5_0001, 32'hCAFE_F00D, run_at_start)});
        tick();
        check("b2_rb_popped", bus.rb_valid, 1'b0);
        bus.rb_ready = 1'b0;

        // Reset during SHIFT cycle 20
        request(32'h1111_2222, 32'h3333_4444);
        wait_shift_start("r_start");
        repeat (20) tick();
        check("r_pre_cfg_en", cfg_en, 1'b1);
        rst_n = 1'b0;
        tick();
        check("r_cfg_en", cfg_en, 1'b0);
        check("r_rbv", bus.rb_valid, 1'b0);
        check("r_ks", ks_count, 16'd0);
        check("r_cipher", cipher_reg, 64'h0000_0060_0000_0055);
        rst_n = 1'b1;
        tick();
        check("r_after_cfg_en", cfg_en, 1'b0);
        check("r_after_ks", ks_count, 16'd1);

        // Saturation of the keystream counter
        repeat (65533) tick();
        check("sat_fffe", ks_count, 16'hFFFE);
        tick();
        check("sat_ffff", ks_count, 16'hFFFF);
        repeat (6) tick();
        check("sat_hold", ks_count, 16'hFFFF);
        check("sat_rbv", bus.rb_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
